// File: rtl/alu_result_writeback.sv
// alu_result_writeback: buffers ALU results in a small FIFO and hands the
// head entry to the writeback/bypass bus under a valid/ready handshake.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   flush_i                    discard all buffered entries
//   fu_valid_i / fu_ready_o    ALU-side handshake
//   result_i, flags_i,
//   dest_phys_i, al_id_i       ALU payload
//   wb_valid_o / wb_ready_i    writeback-side handshake
//   wb_we_o, wb_dest_o,
//   wb_data_o                  register-file write port (gated by wb_valid_o)
//   ctrl_*_o                   active-list completion info (gated by wb_valid_o)
//   exc_count_o                saturating count of popped exception entries
module alu_result_writeback #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FLAGS_W = 6,
  parameter int unsigned PHYS_W  = 7,
  parameter int unsigned AL_W    = 7,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               fu_valid_i,
  output logic               fu_ready_o,
  input  logic [DATA_W-1:0]  result_i,
  input  logic [FLAGS_W-1:0] flags_i,
  input  logic [PHYS_W-1:0]  dest_phys_i,
  input  logic [AL_W-1:0]    al_id_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic               wb_we_o,
  output logic [PHYS_W-1:0]  wb_dest_o,
  output logic [DATA_W-1:0]  wb_data_o,
  output logic [AL_W-1:0]    ctrl_al_id_o,
  output logic               ctrl_executed_o,
  output logic               ctrl_exception_o,
  output logic               ctrl_mispredict_o,
  output logic [CNT_W-1:0]   exc_count_o
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
  localparam int unsigned F_WE   = 4;
  localparam int unsigned F_EXEC = 2;
  localparam int unsigned F_EXC  = 1;
  localparam int unsigned F_MISP = 0;

  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [FLAGS_W-1:0] flags_q [DEPTH];
  logic [PHYS_W-1:0]  dest_q  [DEPTH];
  logic [AL_W-1:0]    al_q    [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [OCC_W-1:0]   count_q;
  logic [CNT_W-1:0]   exc_cnt_q;

  logic               push;
  logic               pop;
  logic [FLAGS_W-1:0] head_flags;
  logic               unused_rsvd;

  // Handshake status comes from registered occupancy only.
  assign fu_ready_o = (count_q != OCC_W'(DEPTH));
  assign wb_valid_o = (count_q != '0);

  assign push = fu_valid_i & fu_ready_o & ~flush_i;
  assign pop  = wb_valid_o & wb_ready_i & ~flush_i;

  assign head_flags  = flags_q[rd_ptr_q];
  // Reserved flag bits travel with the entry but drive nothing.
  assign unused_rsvd = ^{head_flags[5], head_flags[3]};

  // Head presentation, forced to zero whenever the buffer is empty.
  assign wb_we_o           = wb_valid_o & head_flags[F_WE];
  assign wb_dest_o         = wb_valid_o ? dest_q[rd_ptr_q] : '0;
  assign wb_data_o         = wb_valid_o ? data_q[rd_ptr_q] : '0;
  assign ctrl_al_id_o      = wb_valid_o ? al_q[rd_ptr_q]   : '0;
  assign ctrl_executed_o   = wb_valid_o & head_flags[F_EXEC];
  assign ctrl_exception_o  = wb_valid_o & head_flags[F_EXC];
  assign ctrl_mispredict_o = wb_valid_o & head_flags[F_MISP];
  assign exc_count_o       = exc_cnt_q;

  // Entry storage; contents are don't-care until marked valid by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q]  <= result_i;
      flags_q[wr_ptr_q] <= flags_i;
      dest_q[wr_ptr_q]  <= dest_phys_i;
      al_q[wr_ptr_q]    <= al_id_i;
    end
  end

  // Pointers and occupancy; reset outranks flush, flush outranks traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Exception counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_cnt_q <= '0;
    end else if (pop && head_flags[F_EXC] && (exc_cnt_q != '1)) begin
      exc_cnt_q <= exc_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
module tb_alu_result_writeback;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        flush_i;
  logic        fu_valid_i;
  logic [31:0] result_i;
  logic [5:0]  flags_i;
  logic [6:0]  dest_phys_i;
  logic [6:0]  al_id_i;
  logic        wb_ready_i;

  logic        fu_ready_o, wb_valid_o, wb_we_o;
  logic [6:0]  wb_dest_o, ctrl_al_id_o;
  logic [31:0] wb_data_o;
  logic        ctrl_executed_o, ctrl_exception_o, ctrl_mispredict_o;
  logic [15:0] exc_count_o;

  // Narrow-counter copy fed the same stimulus, to reach saturation quickly.
  logic        s_fu_ready, s_wb_valid, s_wb_we;
  logic [6:0]  s_wb_dest, s_al_id;
  logic [31:0] s_wb_data;
  logic        s_exec, s_exc, s_misp;
  logic [2:0]  s_exc_count;

  alu_result_writeback dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .fu_valid_i(fu_valid_i), .fu_ready_o(fu_ready_o),
    .result_i(result_i), .flags_i(flags_i),
    .dest_phys_i(dest_phys_i), .al_id_i(al_id_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_we_o(wb_we_o), .wb_dest_o(wb_dest_o), .wb_data_o(wb_data_o),
    .ctrl_al_id_o(ctrl_al_id_o), .ctrl_executed_o(ctrl_executed_o),
    .ctrl_exception_o(ctrl_exception_o), .ctrl_mispredict_o(ctrl_mispredict_o),
    .exc_count_o(exc_count_o)
  );

  alu_result_writeback #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .fu_valid_i(fu_valid_i), .fu_ready_o(s_fu_ready),
    .result_i(result_i), .flags_i(flags_i),
    .dest_phys_i(dest_phys_i), .al_id_i(al_id_i),
    .wb_valid_o(s_wb_valid), .wb_ready_i(wb_ready_i),
    .wb_we_o(s_wb_we), .wb_dest_o(s_wb_dest), .wb_data_o(s_wb_data),
    .ctrl_al_id_o(s_al_id), .ctrl_executed_o(s_exec),
    .ctrl_exception_o(s_exc), .ctrl_mispredict_o(s_misp),
    .exc_count_o(s_exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of accepted entries plus an exception tally.
  typedef struct {
    logic [31:0] res;
    logic [5:0]  flg;
    logic [6:0]  dst;
    logic [6:0]  al;
  } ent_t;

  ent_t q[$];
  int   m_exc = 0;
  bit   model_ok = 0;

  task automatic model_check();
    ent_t h;
    bit   v;
    v = (q.size() > 0);
    h = v ? q[0] : '{32'h0, 6'h0, 7'h0, 7'h0};
    chk("m_fu_ready", 32'(fu_ready_o), 32'(q.size() < DEPTH));
    chk("m_wb_valid", 32'(wb_valid_o), 32'(v));
    chk("m_wb_we",    32'(wb_we_o),    32'(h.flg[4]));
    chk("m_wb_dest",  32'(wb_dest_o),  32'(h.dst));
    chk("m_wb_data",  wb_data_o,       h.res);
    chk("m_al_id",    32'(ctrl_al_id_o), 32'(h.al));
    chk("m_exec",     32'(ctrl_executed_o),   32'(h.flg[2]));
    chk("m_exc",      32'(ctrl_exception_o),  32'(h.flg[1]));
    chk("m_misp",     32'(ctrl_mispredict_o), 32'(h.flg[0]));
    chk("m_exc_count", 32'(exc_count_o), (m_exc > 65535) ? 32'd65535 : 32'(m_exc));
    chk("m_sat_count", 32'(s_exc_count), (m_exc > 7) ? 32'd7 : 32'(m_exc));
    chk("m_sat_data",  s_wb_data, h.res);
  endtask

  task automatic model_update();
    bit do_pop, do_push;
    if (reset) begin
      q.delete();
      m_exc = 0;
      model_ok = 1;
    end else if (flush_i) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && wb_ready_i;
      do_push = fu_valid_i && (q.size() < DEPTH);
      if (do_pop) begin
        if (q[0].flg[1]) m_exc++;
        void'(q.pop_front());
      end
      if (do_push) q.push_back('{result_i, flags_i, dest_phys_i, al_id_i});
    end
  endtask

  // One clock: compare before the edge, advance the model at the edge.
  task automatic step();
    @(negedge clk);
    if (model_ok) model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        rst, fl, fv, wr;
    logic [31:0] res;
    logic [5:0]  flg;
    logic [6:0]  dst, al;
    logic        ev, er, ewe, eexc;
    logic [31:0] edata;
    logic [6:0]  edest;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(input logic rst, fl, fv, wr, input logic [31:0] res,
                              input logic [5:0] flg, input logic [6:0] dst, al,
                              input logic ev, er, ewe, eexc, input logic [31:0] edata,
                              input logic [6:0] edest, input logic [15:0] ecnt);
    mk = '{rst, fl, fv, wr, res, flg, dst, al, ev, er, ewe, eexc, edata, edest, ecnt};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst fl fv wr  res    flags      dst  al   ev er we ex data   dest ecnt
    vt[0]  = mk(1, 0, 0, 0, 32'h0,  6'b000000, 7'd0,  7'd0, 0, 1, 0, 0, 32'h0,  7'd0,  16'd0);
    vt[1]  = mk(0, 0, 1, 0, 32'h5,  6'b010100, 7'd12, 7'd3, 1, 1, 1, 0, 32'h5,  7'd12, 16'd0);
    vt[2]  = mk(0, 0, 0, 0, 32'h0,  6'b000000, 7'd0,  7'd0, 1, 1, 1, 0, 32'h5,  7'd12, 16'd0);
    vt[3]  = mk(0, 0, 0, 1, 32'h0,  6'b000000, 7'd0,  7'd0, 0, 1, 0, 0, 32'h0,  7'd0,  16'd0);
    vt[4]  = mk(0, 0, 1, 0, 32'hA,  6'b010100, 7'd1,  7'd4, 1, 1, 1, 0, 32'hA,  7'd1,  16'd0);
    vt[5]  = mk(0, 0, 1, 0, 32'hB,  6'b010100, 7'd2,  7'd5, 1, 0, 1, 0, 32'hA,  7'd1,  16'd0);
    vt[6]  = mk(0, 0, 1, 0, 32'hC,  6'b010100, 7'd3,  7'd6, 1, 0, 1, 0, 32'hA,  7'd1,  16'd0);
    vt[7]  = mk(0, 0, 0, 1, 32'h0,  6'b000000, 7'd0,  7'd0, 1, 1, 1, 0, 32'hB,  7'd2,  16'd0);
    vt[8]  = mk(0, 0, 0, 1, 32'h0,  6'b000000, 7'd0,  7'd0, 0, 1, 0, 0, 32'h0,  7'd0,  16'd0);
    vt[9]  = mk(0, 0, 1, 0, 32'h77, 6'b000100, 7'd5,  7'd7, 1, 1, 0, 0, 32'h77, 7'd5,  16'd0);
    vt[10] = mk(0, 0, 1, 0, 32'h78, 6'b010100, 7'd6,  7'd8, 1, 0, 0, 0, 32'h77, 7'd5,  16'd0);
    vt[11] = mk(1, 0, 1, 1, 32'h99, 6'b010110, 7'd9,  7'd9, 0, 1, 0, 0, 32'h0,  7'd0,  16'd0);
    vt[12] = mk(0, 0, 1, 1, 32'h1,  6'b010110, 7'd20, 7'd1, 1, 1, 1, 1, 32'h1,  7'd20, 16'd0);
    vt[13] = mk(0, 0, 1, 1, 32'h2,  6'b010110, 7'd21, 7'd2, 1, 1, 1, 1, 32'h2,  7'd21, 16'd1);
    vt[14] = mk(0, 0, 1, 1, 32'h3,  6'b010110, 7'd22, 7'd3, 1, 1, 1, 1, 32'h3,  7'd22, 16'd2);
    vt[15] = mk(0, 0, 0, 1, 32'h0,  6'b000000, 7'd0,  7'd0, 0, 1, 0, 0, 32'h0,  7'd0,  16'd3);
    vt[16] = mk(0, 0, 1, 0, 32'h10, 6'b010100, 7'd30, 7'd1, 1, 1, 1, 0, 32'h10, 7'd30, 16'd3);
    vt[17] = mk(0, 0, 1, 0, 32'h11, 6'b010100, 7'd31, 7'd2, 1, 0, 1, 0, 32'h10, 7'd30, 16'd3);
    vt[18] = mk(0, 1, 1, 1, 32'h12, 6'b010110, 7'd32, 7'd3, 0, 1, 0, 0, 32'h0,  7'd0,  16'd3);
    vt[19] = mk(0, 0, 0, 1, 32'h0,  6'b000000, 7'd0,  7'd0, 0, 1, 0, 0, 32'h0,  7'd0,  16'd3);

    reset = 1'b1; flush_i = 1'b0; fu_valid_i = 1'b0; wb_ready_i = 1'b0;
    result_i = '0; flags_i = '0; dest_phys_i = '0; al_id_i = '0;
    @(posedge clk); #1;

    // Directed vectors: expectations are the state right after each edge.
    for (int i = 0; i < 20; i++) begin
      reset = vt[i].rst; flush_i = vt[i].fl; fu_valid_i = vt[i].fv; wb_ready_i = vt[i].wr;
      result_i = vt[i].res; flags_i = vt[i].flg; dest_phys_i = vt[i].dst; al_id_i = vt[i].al;
      step();
      chk($sformatf("v%0d_valid", i), 32'(wb_valid_o), 32'(vt[i].ev));
      chk($sformatf("v%0d_ready", i), 32'(fu_ready_o), 32'(vt[i].er));
      chk($sformatf("v%0d_we", i),    32'(wb_we_o),    32'(vt[i].ewe));
      chk($sformatf("v%0d_exc", i),   32'(ctrl_exception_o), 32'(vt[i].eexc));
      chk($sformatf("v%0d_data", i),  wb_data_o, vt[i].edata);
      chk($sformatf("v%0d_dest", i),  32'(wb_dest_o), 32'(vt[i].edest));
      chk($sformatf("v%0d_cnt", i),   32'(exc_count_o), 32'(vt[i].ecnt));
    end
    chk("nop_executed_seen", 32'(ctrl_executed_o), 32'd0);

    // Streaming: one result per cycle in order, buffer stays at one entry.
    reset = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1; fu_valid_i = 1'b1; flags_i = 6'b010100;
    for (int i = 1; i <= 8; i++) begin
      result_i = 32'(i); dest_phys_i = 7'(i); al_id_i = 7'(i + 40);
      step();
      chk($sformatf("stream%0d_data", i), wb_data_o, 32'(i));
      chk($sformatf("stream%0d_ready", i), 32'(fu_ready_o), 32'd1);
    end
    fu_valid_i = 1'b0;
    step();
    chk("stream_drained", 32'(wb_valid_o), 32'd0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 2000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      flush_i    = ($urandom_range(0, 39) == 0);
      fu_valid_i = 1'($urandom);
      wb_ready_i = ($urandom_range(0, 3) != 0);
      result_i   = $urandom;
      flags_i    = 6'($urandom);
      dest_phys_i = 7'($urandom);
      al_id_i    = 7'($urandom);
      step();
    end
    reset = 1'b0; flush_i = 1'b0; fu_valid_i = 1'b0; wb_ready_i = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
